machine_trap_ctrl: RTL and testbench

MACHINE_TRAP_CTRL -- requirements
Module: machine_trap_ctrl

---
 rtl/machine_trap_ctrl.sv | 97 +++++++++
 tb/tb_machine_trap_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/machine_trap_ctrl.sv
// machine_trap_ctrl: machine-mode trap/return sequencer (IDLE -> SAVE -> JUMP, IDLE -> RET)
// Ports:
//   clock, rst_n_in                           clock and asynchronous active-low reset
//   instr_valid_in, pc_in                     execute-stage instruction and its PC
//   misaligned_in .. mret_in                  exception / return flags (qualified by instr_valid_in)
//   irq_ext_in, irq_timer_in                  level interrupt requests
//   mie_in, meie_in, mtie_in                  global / external / timer interrupt enables
//   mtvec_in, epc_in                          trap vector and current MEPC
//   set_epc_out, epc_pc_out                   MEPC write strobe and value
//   set_cause_out, cause_out                  MCAUSE write strobe and value
//   mie_clear_out, mie_restore_out            mstatus MIE save / restore strobes
//   kill_out, busy_out                        squash execute instruction / stall upstream
//   redirect_out, redirect_pc_out             fetch redirect strobe and target
// Build option: define TRAP_VECTORED_EN to vector interrupts when mtvec mode is 2'b01.
module machine_trap_ctrl (
  input  logic        clock,
  input  logic        rst_n_in,
  input  logic        instr_valid_in,
  input  logic [31:0] pc_in,
  input  logic        misaligned_in,
  input  logic        illegal_in,
  input  logic        ebreak_in,
  input  logic        ecall_in,
  input  logic        mret_in,
  input  logic        irq_ext_in,
  input  logic        irq_timer_in,
  input  logic        mie_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] epc_in,
  output logic        set_epc_out,
  output logic [31:0] epc_pc_out,
  output logic        set_cause_out,
  output logic [31:0] cause_out,
  output logic        mie_clear_out,
  output logic        mie_restore_out,
  output logic        kill_out,
  output logic        busy_out,
  output logic        redirect_out,
  output logic [31:0] redirect_pc_out
);
  typedef enum logic [1:0] {IDLE, SAVE, JUMP, RET} state_t;
  state_t      state, state_nx;
  logic [31:2] pc_q;
  logic [31:0] cause_q, cause_nx, base, jump_pc;
  logic        ext_en, tmr_en, exc, trap, ret, unused;
  assign ext_en   = mie_in & irq_ext_in & meie_in;
  assign tmr_en   = mie_in & irq_timer_in & mtie_in;
  assign exc      = misaligned_in | illegal_in | ebreak_in | ecall_in;
  assign trap     = instr_valid_in & (exc | ext_en | tmr_en);
  assign ret      = instr_valid_in & mret_in & ~trap;
  assign cause_nx = misaligned_in ? 32'd0 :
                    illegal_in    ? 32'd2 :
                    ebreak_in     ? 32'd3 :
                    ecall_in      ? 32'd11 :
                    ext_en        ? 32'h8000_000B : 32'h8000_0007;
  assign base     = {mtvec_in[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign jump_pc  = (mtvec_in[1:0] == 2'b01 && cause_q[31]) ? base + {cause_q[29:0], 2'b00} : base;
`else
  assign jump_pc  = base;
`endif
  assign unused   = ^{pc_in[1:0], epc_in[1:0], mtvec_in[1:0], cause_q[30]};
  always_ff @(posedge clock or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end
  always_ff @(posedge clock or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q    <= '0;
      cause_q <= '0;
    end else if (state == IDLE && trap) begin
      pc_q    <= pc_in[31:2];
      cause_q <= cause_nx;
    end
  end
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = trap ? SAVE : (ret ? RET : IDLE);
    else if (state == SAVE) state_nx = JUMP;
  end
  // kill is combinational from inputs, so it is gated by reset explicitly
  always_comb begin
    kill_out        = rst_n_in && state == IDLE && (trap || ret);
    busy_out        = state != IDLE;
    set_epc_out     = state == SAVE;
    set_cause_out   = state == SAVE;
    mie_clear_out   = state == SAVE;
    mie_restore_out = state == RET;
    redirect_out    = state == JUMP || state == RET;
    epc_pc_out      = state == SAVE ? {pc_q, 2'b00} : 32'd0;
    cause_out       = state == SAVE ? cause_q : 32'd0;
    redirect_pc_out = state == JUMP ? jump_pc :
                      state == RET  ? {epc_in[31:2], 2'b00} : 32'd0;
  end
endmodule

// File: tb/tb_machine_trap_ctrl.sv
// tb_machine_trap_ctrl: table-driven directed test of machine_trap_ctrl
module tb_machine_trap_ctrl;
  logic        clock = 0, rst_n_in = 0;
  logic        instr_valid_in, misaligned_in, illegal_in, ebreak_in, ecall_in, mret_in;
  logic        irq_ext_in, irq_timer_in, mie_in, meie_in, mtie_in;
  logic [31:0] pc_in, mtvec_in, epc_in;
  logic        set_epc_out, set_cause_out, mie_clear_out, mie_restore_out;
  logic        kill_out, busy_out, redirect_out;
  logic [31:0] epc_pc_out, cause_out, redirect_pc_out;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  machine_trap_ctrl dut (
    .clock(clock), .rst_n_in(rst_n_in), .instr_valid_in(instr_valid_in), .pc_in(pc_in),
    .misaligned_in(misaligned_in), .illegal_in(illegal_in), .ebreak_in(ebreak_in),
    .ecall_in(ecall_in), .mret_in(mret_in), .irq_ext_in(irq_ext_in), .irq_timer_in(irq_timer_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .mtvec_in(mtvec_in), .epc_in(epc_in),
    .set_epc_out(set_epc_out), .epc_pc_out(epc_pc_out), .set_cause_out(set_cause_out),
    .cause_out(cause_out), .mie_clear_out(mie_clear_out), .mie_restore_out(mie_restore_out),
    .kill_out(kill_out), .busy_out(busy_out), .redirect_out(redirect_out),
    .redirect_pc_out(redirect_pc_out)
  );
`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1;
`else
  localparam bit VEC = 0;
`endif
  typedef struct {
    string       name;
    logic        v, mis, ill, ebk, ecl, mret, ext, tmr, mie, meie, mtie;
    logic [31:0] pc, mtvec, epc;
    int          kind;
    logic [31:0] cause, epc_x, redir;
  } vec_t;
  vec_t vecs [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_out(input string name, input logic busy, input logic sepc,
                            input logic [31:0] epcpc, input logic scause, input logic [31:0] cause,
                            input logic clr, input logic rst, input logic redir,
                            input logic [31:0] rpc, input logic kill);
    chk({name, ".busy"}, 32'(busy_out), 32'(busy));
    chk({name, ".set_epc"}, 32'(set_epc_out), 32'(sepc));
    chk({name, ".epc_pc"}, epc_pc_out, epcpc);
    chk({name, ".set_cause"}, 32'(set_cause_out), 32'(scause));
    chk({name, ".cause"}, cause_out, cause);
    chk({name, ".mie_clear"}, 32'(mie_clear_out), 32'(clr));
    chk({name, ".mie_restore"}, 32'(mie_restore_out), 32'(rst));
    chk({name, ".redirect"}, 32'(redirect_out), 32'(redir));
    chk({name, ".redirect_pc"}, redirect_pc_out, rpc);
    chk({name, ".kill"}, 32'(kill_out), 32'(kill));
  endtask
  task automatic idle_inputs();
    {instr_valid_in, misaligned_in, illegal_in, ebreak_in, ecall_in, mret_in} = '0;
    {irq_ext_in, irq_timer_in, mie_in, meie_in, mtie_in} = '0;
    pc_in = 0; mtvec_in = 0; epc_in = 0;
  endtask
  task automatic drive(input vec_t t);
    instr_valid_in = t.v; misaligned_in = t.mis; illegal_in = t.ill; ebreak_in = t.ebk;
    ecall_in = t.ecl; mret_in = t.mret; irq_ext_in = t.ext; irq_timer_in = t.tmr;
    mie_in = t.mie; meie_in = t.meie; mtie_in = t.mtie;
    pc_in = t.pc; mtvec_in = t.mtvec; epc_in = t.epc;
  endtask
  task automatic run_vec(input vec_t t);
    @(negedge clock);
    drive(t);
    #1;
    chk({t.name, ".detect_kill"}, 32'(kill_out), 32'(t.kind != 0));
    chk({t.name, ".detect_busy"}, 32'(busy_out), 32'd0);
    @(posedge clock); #1;
    if (t.kind == 1) begin
      expect_out({t.name, ".save"}, 1, 1, t.epc_x, 1, t.cause, 1, 0, 0, 0, 0);
      @(posedge clock); #1;
      expect_out({t.name, ".jump"}, 1, 0, 0, 0, 0, 0, 0, 1, t.redir, 0);
      idle_inputs();
      @(posedge clock); #1;
    end else if (t.kind == 2) begin
      expect_out({t.name, ".ret"}, 1, 0, 0, 0, 0, 0, 1, 1, t.redir, 0);
      idle_inputs();
      @(posedge clock); #1;
    end
    expect_out({t.name, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
  endtask
  initial begin
    //          name      v  mis ill ebk ecl mret ext tmr mie meie mtie pc            mtvec         epc           kind cause          epc_x         redir
    vecs[0]  = '{"illegal",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100,  32'h200,  32'h0,   1, 32'h2,          32'h100,  32'h200};
    vecs[1]  = '{"ecall_ext", 1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 32'h204,  32'h200,  32'h0,   1, 32'hB,          32'h204,  32'h200};
    vecs[2]  = '{"timer_vec", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h3000, 32'h1001, 32'h0,   1, 32'h8000_0007, 32'h3000, VEC ? 32'h101C : 32'h1000};
    vecs[3]  = '{"mret",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h400,  32'h200,  32'h343, 2, 32'h0,          32'h0,    32'h340};
    vecs[4]  = '{"ext_nomie", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h500,  32'h200,  32'h0,   0, 32'h0,          32'h0,    32'h0};
    vecs[5]  = '{"misalign",  1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h13,   32'h200,  32'h0,   1, 32'h0,          32'h10,   32'h200};
    vecs[6]  = '{"ebreak",    1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h40,   32'h204,  32'h0,   1, 32'h3,          32'h40,   32'h204};
    vecs[7]  = '{"ext_tmr",   1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h50,   32'h1001, 32'h0,   1, 32'h8000_000B, 32'h50,   VEC ? 32'h102C : 32'h1000};
    vecs[8]  = '{"tmr_mret",  1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h60,   32'h203,  32'h777, 1, 32'h8000_0007, 32'h60,   32'h200};
    vecs[9]  = '{"novalid",   0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 32'h70,   32'h200,  32'h0,   0, 32'h0,          32'h0,    32'h0};
    vecs[10] = '{"irq_mask",  1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h80,   32'h200,  32'h0,   0, 32'h0,          32'h0,    32'h0};
    vecs[11] = '{"exc_vecmd", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h90,   32'h1001, 32'h0,   1, 32'h2,          32'h90,   32'h1000};
    vecs[12] = '{"mret_ret2", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hA0,   32'h200,  32'h1002, 2, 32'h0,         32'h0,    32'h1000};
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    illegal_in = 1; instr_valid_in = 1; #1;
    chk("reset.kill_gated", 32'(kill_out), 32'd0);
    idle_inputs();
    @(negedge clock);
    rst_n_in = 1;
    for (int i = 0; i < 13; i++) run_vec(vecs[i]);
    @(negedge clock);
    drive(vecs[0]);
    @(posedge clock); #1;
    chk("midrst.in_save", 32'(set_epc_out), 32'd1);
    rst_n_in = 0;
    #1;
    expect_out("midrst.async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    @(posedge clock); #1;
    expect_out("midrst.nojump", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    rst_n_in = 1;
    @(posedge clock); #1;
    expect_out("midrst.after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_vec(vecs[6]);
    run_vec(vecs[3]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
